// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a 1-write/1-read RAM with a registered read port, exposed as valid/ready streams.
// Define RAM_FIFO_CTRL_FLUSH_EN to add a flush input that discards every held word.
module ram_fifo_ctrl #(
   parameter int dataWidth = 32,
   parameter int depthLog2 = 4
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef RAM_FIFO_CTRL_FLUSH_EN
   input  logic                 flush,
`endif
   input  logic                 push_valid,
   output logic                 push_ready,
   input  logic [dataWidth-1:0] push_payload,
   output logic                 pop_valid,
   input  logic                 pop_ready,
   output logic [dataWidth-1:0] pop_payload,
   output logic [depthLog2+1:0] occupancy,
   output logic                 ram_wr_en,
   output logic                 ram_wr_mask,
   output logic [depthLog2-1:0] ram_wr_addr,
   output logic [dataWidth-1:0] ram_wr_data,
   output logic                 ram_rd_en,
   output logic [depthLog2-1:0] ram_rd_addr,
   input  logic [dataWidth-1:0] ram_rd_data
);
   localparam int PtrWidth = depthLog2 + 1;
   localparam logic [PtrWidth-1:0] FullCount = {1'b1, {depthLog2{1'b0}}};

   logic [PtrWidth-1:0]  wptr_reg, wptr_next;
   logic [PtrWidth-1:0]  rptr_reg, rptr_next;
   logic                 rd_pending_reg, rd_pending_next;
   logic [1:0]           out_count_reg, out_count_next;
   logic [dataWidth-1:0] queue_reg [2];
   logic [dataWidth-1:0] queue_next [2];

   logic [PtrWidth-1:0]  ram_count;
   logic                 push_fire;
   logic                 pop_fire;
   logic                 rd_issue;
   logic [2:0]           committed;
   logic [1:0]           kept;

   // Writes become visible to ram_count only after their edge, so a read never targets the word being written.
   assign ram_count   = wptr_reg - rptr_reg;
   assign push_ready  = (ram_count != FullCount);
   assign push_fire   = push_valid & push_ready;

   assign pop_valid   = (out_count_reg != 2'd0);
   assign pop_fire    = pop_valid & pop_ready;
   assign pop_payload = queue_reg[0];

   // Slots of the output queue already claimed once this cycle's pop is accounted for.
   assign committed = {1'b0, out_count_reg} + {2'b00, rd_pending_reg} - {2'b00, pop_fire};
   assign rd_issue  = (ram_count != '0) && (committed < 3'd2);
   assign kept      = out_count_reg - {1'b0, pop_fire};

   assign ram_wr_en   = push_fire;
   assign ram_wr_mask = 1'b1;
   assign ram_wr_addr = wptr_reg[depthLog2-1:0];
   assign ram_wr_data = push_payload;
   assign ram_rd_en   = rd_issue;
   assign ram_rd_addr = rptr_reg[depthLog2-1:0];

   assign occupancy = {1'b0, ram_count}
                    + {{(depthLog2+1){1'b0}}, rd_pending_reg}
                    + {{depthLog2{1'b0}}, out_count_reg};

   always_comb begin
      wptr_next       = wptr_reg + PtrWidth'(push_fire);
      rptr_next       = rptr_reg + PtrWidth'(rd_issue);
      rd_pending_next = rd_issue;
      out_count_next  = out_count_reg + {1'b0, rd_pending_reg} - {1'b0, pop_fire};
      queue_next[0]   = pop_fire ? queue_reg[1] : queue_reg[0];
      queue_next[1]   = queue_reg[1];
      // The returning word lands right behind whatever survives this cycle's pop.
      if (rd_pending_reg) begin
         if (kept == 2'd0) begin
            queue_next[0] = ram_rd_data;
         end else begin
            queue_next[1] = ram_rd_data;
         end
      end
`ifdef RAM_FIFO_CTRL_FLUSH_EN
      if (flush) begin
         rptr_next       = wptr_reg;
         rd_pending_next = 1'b0;
         out_count_next  = 2'd0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      queue_reg[0] <= queue_next[0];
      queue_reg[1] <= queue_next[1];
      if (reset) begin
         wptr_reg       <= '0;
         rptr_reg       <= '0;
         rd_pending_reg <= 1'b0;
         out_count_reg  <= 2'd0;
      end else begin
         wptr_reg       <= wptr_next;
         rptr_reg       <= rptr_next;
         rd_pending_reg <= rd_pending_next;
         out_count_reg  <= out_count_next;
      end
   end

endmodule
